// File: rtl/spi_trace_slave.sv
// spi_trace_slave: oversampled SPI slave that streams trace-FIFO
// words in fixed-size frames and decodes trace-control commands.
module spi_trace_slave #(
  parameter int          WORD_BYTES  = 2,
  parameter int          FRAME_WORDS = 8,
  parameter int          FIFO_DEPTH  = 16,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ACT_STRETCH = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sclk,
  input  logic                    sel,
  input  logic                    mosi,
  output logic                    miso,
  input  logic                    tr_valid,
  input  logic [8*WORD_BYTES-1:0] tr_data,
  output logic                    tr_ready,
  input  logic                    tr_sync,
  output logic [2:0]              width_enc,
  output logic                    frame_reset,
  output logic                    is_transmitting,
  output logic                    overflow
);

  localparam int WW = 8 * WORD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    CMD,
    HDR,
    DATA
  } state_t;

  // ---------------- pin synchronisers ----------------
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] sel_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_d;
  logic                   sclk_s;
  logic                   sel_s;
  logic                   mosi_s;

  // Shift the raw SPI pins into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_q <= {SYNC_STAGES{CPOL}};
      sel_q  <= '1;
      mosi_q <= '0;
      sclk_d <= CPOL;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sel_q  <= {sel_q[SYNC_STAGES-2:0], sel};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign sel_s  = sel_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // ---------------- edge decode ----------------
  logic rise;
  logic fall;
  logic lead;
  logic trail;
  logic samp;
  logic shft;

  assign rise  = sclk_s & ~sclk_d;
  assign fall  = ~sclk_s & sclk_d;
  assign lead  = CPOL ? fall : rise;
  assign trail = CPOL ? rise : fall;
  assign samp  = CPHA ? trail : lead;
  assign shft  = CPHA ? lead : trail;

  // ---------------- trace FIFO ----------------
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [WW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full     = (level == LW'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign tr_ready = ~full;
  assign push     = tr_valid & ~full;
  assign head     = mem[rd_ptr];

  // Storage array; no reset needed, level guards reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tr_data;
    end
  end

  // Pointers and fill level; a push at full is already blocked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // ---------------- protocol state ----------------
  state_t        state;
  logic [2:0]    bitcnt;
  logic [6:0]    rx_sh;
  logic [7:0]    tx_sh;
  logic          fresh;
  logic [1:0]    width;
  logic          frame_real;
  logic [3:0]    wordcnt;
  logic [1:0]    bytecnt;
  logic [WW-1:0] word_q;
  logic [15:0]   act_cnt;

  logic [7:0]    rx_byte;
  logic          byte_done;
  logic          is_width_cmd;
  logic          hdr_load;
  logic          hdr_real;
  logic          stat_rd;
  logic [31:0]   lvl32;
  logic [4:0]    lvl_sat;
  logic [7:0]    stat_byte;
  logic [WW-1:0] src_word;
  logic [7:0]    data_byte;

  function automatic logic [7:0] hdr_byte(
    input logic       r,
    input logic [1:0] w,
    input logic       s
  );
    return {r, 4'b0000, w, s};
  endfunction

  assign rx_byte      = {rx_sh, mosi_s};
  assign byte_done    = ~sel_s & samp & (bitcnt == 3'd7);
  assign is_width_cmd = (rx_byte[7:2] == 6'b100000);
  assign hdr_real     = (level >= LW'(FRAME_WORDS));
  assign hdr_load     = byte_done &
                        ((state == HDR) |
                         ((state == CMD) & is_width_cmd));
  assign stat_rd      = byte_done & (state == CMD) &
                        (rx_byte == 8'hC0);
  assign pop          = byte_done & (state == DATA) &
                        (bytecnt == 2'd0) & frame_real;

  assign lvl32     = 32'(level);
  assign lvl_sat   = (lvl32 > 32'd31) ? 5'd31 : lvl32[4:0];
  assign stat_byte = {full, empty, overflow, lvl_sat};

  // Byte 0 of a word comes straight off the FIFO head.
  assign src_word  = (bytecnt == 2'd0) ? head : word_q;
  assign data_byte = 8'(src_word >> {bytecnt, 3'b000});

  // Bit engine, command decode and frame sequencing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= CMD;
      bitcnt      <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      fresh       <= 1'b1;
      width       <= 2'd3;
      frame_real  <= 1'b0;
      wordcnt     <= '0;
      bytecnt     <= '0;
      word_q      <= '0;
      frame_reset <= 1'b0;
    end else begin
      frame_reset <= 1'b0;
      if (sel_s) begin
        state   <= CMD;
        bitcnt  <= '0;
        tx_sh   <= '0;
        fresh   <= 1'b1;
        wordcnt <= '0;
        bytecnt <= '0;
      end else if (samp) begin
        rx_sh  <= rx_byte[6:0];
        bitcnt <= bitcnt + 3'd1;
        if (byte_done) begin
          fresh <= 1'b1;
          unique case (state)
            CMD: begin
              tx_sh <= 8'h00;
              if (rx_byte == 8'hA5) begin
                frame_reset <= 1'b1;
              end else if (is_width_cmd) begin
                width      <= rx_byte[1:0];
                frame_real <= hdr_real;
                tx_sh      <= hdr_byte(hdr_real, rx_byte[1:0],
                                       tr_sync);
                state      <= DATA;
                wordcnt    <= 4'(FRAME_WORDS);
                bytecnt    <= '0;
              end else if (rx_byte == 8'hC0) begin
                tx_sh <= stat_byte;
              end
            end
            HDR: begin
              frame_real <= hdr_real;
              tx_sh      <= hdr_byte(hdr_real, width, tr_sync);
              state      <= DATA;
              wordcnt    <= 4'(FRAME_WORDS);
              bytecnt    <= '0;
            end
            DATA: begin
              tx_sh <= frame_real ? data_byte : 8'h00;
              if (pop) begin
                word_q <= head;
              end
              if (bytecnt == 2'(WORD_BYTES - 1)) begin
                bytecnt <= '0;
                wordcnt <= wordcnt - 4'd1;
                if (wordcnt == 4'd1) begin
                  state <= HDR;
                end
              end else begin
                bytecnt <= bytecnt + 2'd1;
              end
            end
            default: state <= CMD;
          endcase
        end
      end else if (shft) begin
        if (fresh) begin
          fresh <= 1'b0;
        end else begin
          tx_sh <= {tx_sh[6:0], 1'b0};
        end
      end
    end
  end

  // Sticky overflow; a status read clears it unless a drop
  // happens in the very same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (tr_valid & full) begin
      overflow <= 1'b1;
    end else if (stat_rd) begin
      overflow <= 1'b0;
    end
  end

  // Activity stretch, restarted by every real frame header.
  always_ff @(posedge clk) begin
    if (!rst) begin
      act_cnt <= '0;
    end else if (hdr_load & hdr_real) begin
      act_cnt <= ACT_STRETCH;
    end else if (act_cnt != 16'd0) begin
      act_cnt <= act_cnt - 16'd1;
    end
  end

  assign miso            = tx_sh[7];
  assign width_enc       = {1'b0, width} + 3'd1;
  assign is_transmitting = (act_cnt != 16'd0);

endmodule

// File: doc/spi_trace_slave.md
# spi_trace_slave

Parametrised single-clock SPI slave that streams buffered parallel-trace words to the host in fixed-size frames and accepts trace-control commands. It sits between the trace capture front-end and the FT2232H SPI link. It oversamples the SPI pins in the system clock domain, so no logic runs on the SPI clock. Compared with the earlier bridge it adds configurable SPI mode, word width and frame length, an internal trace FIFO with whole-frame gating, overflow accounting and a status read.

## Interface
- WORD_BYTES, 2, bytes per trace word (1..4)
- FRAME_WORDS, 8, words per trace frame (1..15)
- FIFO_DEPTH, 16, trace FIFO entries, power of 2, ≥ FRAME_WORDS
- CPOL, 0, SPI clock idle level
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- SYNC_STAGES, 2, synchroniser flops on sclk/sel/mosi (≥2)
- ACT_STRETCH, 16'hFFFF, activity stretch length in clk cycles
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- sclk  in  1  SPI clock, asynchronous
- sel  in  1  SPI select, active-low, asynchronous
- mosi  in  1  host→slave data
- miso  out  1  slave→host data
- tr_valid  in  1  trace word offered
- tr_data  in  8*WORD_BYTES  trace word
- tr_ready  out  1  FIFO not full
- tr_sync  in  1  trace front-end synchronised
- width_enc  out  3  trace pin-width code = width+1
- frame_reset  out  1  one-clk pulse on frame-reset command
- is_transmitting  out  1  activity indicator (stretched)
- overflow  out  1  sticky: a word was offered while the FIFO was full

## Operation
- Inputs pass through SYNC_STAGES flops. Edge detect runs on the synchronised sclk. Leading/trailing edges are derived from CPOL. Sample edge and shift edge are derived from CPHA.
- sel high: bit counter = 0, state = CMD, tx shift reg = 0x00, fresh = 1. A partial byte is discarded.
- Bits are MSB first. A byte completes on the 8th sample edge. On completion the next response byte loads into the tx shift reg and fresh is set.
- On a shift edge: if fresh, clear fresh; otherwise shift left by 1. miso = tx_shift[7] continuously.
- The first response byte of every transaction is 0x00.
- States:
  - CMD, decoding the completed byte:
    - 0x00: stay in CMD.
    - 0xA5: pulse frame_reset; stay in CMD.
    - 0x80–0x83: width ← byte[1:0]; go to HDR.
    - 0xC0: go to STAT.
    - Any other byte: stay in CMD; response bytes are 0x00.
  - STAT: load {full, empty, overflow, level[4:0] saturated at 31}. Clear overflow in the same cycle, unless a new overflow occurs in that cycle, in which case it stays set. Go to CMD.
  - HDR: real ← (fifo level ≥ FRAME_WORDS). Load header {real, 4'b0, width[1:0], tr_sync}. If real, reload the activity counter. Go to DATA with wordcnt = FRAME_WORDS and bytecnt = 0.
  - DATA: at bytecnt 0 of each word, pop the FIFO head into the word register only if real. Load word byte[bytecnt], LSB byte first; if not real, load 0x00. After WORD_BYTES bytes, decrement wordcnt. At wordcnt 0, go to HDR. Streaming continues until sel goes high.
- FIFO:
  - Write when tr_valid && tr_ready.
  - tr_ready = !full.
  - tr_valid && full sets overflow; the word is dropped.
  - A simultaneous pop and push at full is allowed only as pop-then-push in the same cycle. tr_ready stays the combinational !full, so a push at full is dropped even if a pop happens in that cycle.
  - Pointers wrap modulo FIFO_DEPTH. Level is 0..FIFO_DEPTH, one bit wider than the pointers.
- Whole-frame gating: a real frame never underflows. Words are not popped in non-real frames.
- is_transmitting = (activity counter ≠ 0). The counter decrements by 1 per clk, saturating at 0.

## Timing
- Reset values: miso 0, tr_ready 1, width_enc 3'd4 (width 3), frame_reset 0, is_transmitting 0, overflow 0. FIFO is empty and state is CMD.
- Pin-to-internal latency: SYNC_STAGES+1 clk.
- sclk high and low phases must each be ≥ SYNC_STAGES+2 clk. sel set-up and hold around sclk edges must be ≥ 2 clk.
- Byte-complete to response load: the same clk as the detected sample edge, ahead of the next shift edge.
- width_enc updates 1 clk after the command byte completes. frame_reset is high for exactly 1 clk.
- A pop occurs in the byte-complete cycle that enters bytecnt 0 of a word. tr_ready rises 1 clk later.
- sel rising mid-byte or mid-frame aborts immediately. Words already popped are lost; words not yet popped remain in the FIFO.
- Reset asserted mid-transaction: all state returns to reset values on the next clk edge.

## Test plan
- Reset, then sel low and send 0x82 followed by 17 bytes, with an empty FIFO → miso 0x00, header 0x04 | tr_sync (non-real; width_enc = 3), then 16 bytes of 0x00.
- Push 8 words 0x1234..0x123B, then send 0x83 and read 17 bytes → header 0x86 with tr_sync = 0, then data 34 12 35 12 … 3B 12. FIFO ends empty; is_transmitting = 1.
- Push 7 words and read a frame → header real = 0, zeros returned, FIFO level still 7.
- Hold tr_valid for FIFO_DEPTH+3 words without reading → tr_ready = 0 after 16 words and overflow = 1. Then send 0xC0 → second byte 0xB0 (full=1, empty=0, ovf=1, level=16), and overflow clears.
- Send 0xA5 → frame_reset is high for 1 clk and state stays CMD. A following 0x00 returns 0x00.
- Deassert sel after 3 bits of the 2nd data word, then restart → the new transaction decodes its first byte as a command and the remaining FIFO words are intact. Repeat the bench for CPOL/CPHA = 0/0, 0/1, 1/0, 1/1.
